// File: rtl/zuse_fpu_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module   : zuse_fpu_addsub_if
//  Purpose  : Request/result bundle of the tinyZuse add/subtract unit.
//             master = requester (drives operands and start),
//             slave  = the unit (drives busy, done, result and flags).
//  Ports    : start, op, a_s/a_e/a_m, b_s/b_e/b_m            (master -> slave)
//             busy, done, res_s/res_e/res_m,
//             zero_flag, overflow_flag, underflow_flag, inf_flag (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface zuse_fpu_addsub_if #(
    parameter int EW = 7,
    parameter int MW = 15
);
    logic          start;
    logic          op;
    logic          a_s;
    logic          b_s;
    logic [EW-1:0] a_e;
    logic [EW-1:0] b_e;
    logic [MW-1:0] a_m;
    logic [MW-1:0] b_m;
    logic          busy;
    logic          done;
    logic          res_s;
    logic [EW-1:0] res_e;
    logic [MW-1:0] res_m;
    logic          zero_flag;
    logic          overflow_flag;
    logic          underflow_flag;
    logic          inf_flag;

    modport master (
        output start, op, a_s, b_s, a_e, b_e, a_m, b_m,
        input  busy, done, res_s, res_e, res_m,
        input  zero_flag, overflow_flag, underflow_flag, inf_flag
    );

    modport slave (
        input  start, op, a_s, b_s, a_e, b_e, a_m, b_m,
        output busy, done, res_s, res_e, res_m,
        output zero_flag, overflow_flag, underflow_flag, inf_flag
    );
endinterface
`default_nettype wire

// File: rtl/zuse_fpu_addsub.sv
`default_nettype none
// ============================================================================
//  Module   : zuse_fpu_addsub
//  Purpose  : Multi-cycle floating-point add/subtract with explicit zero and
//             infinity handling, truncating alignment and bit-serial
//             normalisation. Operands are latched when start is accepted.
//  Ports    : clk   - clock, all logic on the rising edge
//             reset - synchronous, active-high
//             bus   - zuse_fpu_addsub_if.slave (operands, busy/done, result)
//  Revision : 1.0  initial release
// ============================================================================
module zuse_fpu_addsub #(
    parameter int EW = 7,
    parameter int MW = 15
) (
    input  logic             clk,
    input  logic             reset,
    zuse_fpu_addsub_if.slave bus
);
    // Reserved exponent codes and the canonical mantissa used for 0 / inf.
    localparam logic [EW-1:0]        c_e_zero    = {1'b1, {(EW-1){1'b0}}};
    localparam logic [EW-1:0]        c_e_inf     = {1'b0, {(EW-1){1'b1}}};
    localparam logic [MW-1:0]        c_m_one     = {1'b1, {(MW-1){1'b0}}};
    // Largest / smallest exponent a normal result may carry.
    localparam logic signed [EW+1:0] c_e_hi      = (EW+2)'(2**(EW-1) - 2);
    localparam logic signed [EW+1:0] c_e_lo      = (EW+2)'(1 - 2**(EW-1));
    localparam logic signed [EW+1:0] c_e_one     = (EW+2)'(1);
    localparam logic [EW:0]          c_shift_out = (EW+1)'(MW);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPECIAL = 3'd1,
        S_ALIGN   = 3'd2,
        S_ADD     = 3'd3,
        S_NORM    = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_a_s, r_b_s;           // r_b_s already includes op
    logic [EW-1:0]          r_a_e, r_b_e;
    logic [MW-1:0]          r_a_m, r_b_m;
    logic                   r_x_s, r_y_s;
    logic [MW-1:0]          r_x_m, r_y_m;
    logic signed [EW+1:0]   r_ex;
    logic                   r_sign;
    logic [MW-1:0]          r_m;
    logic signed [EW+1:0]   r_e;
    logic                   r_busy, r_done, r_res_s;
    logic [EW-1:0]          r_res_e;
    logic [MW-1:0]          r_res_m;
    logic                   r_zero_f, r_ovf_f, r_unf_f, r_inf_f;

    logic                   w_a_inf, w_a_zero, w_b_inf, w_b_zero;
    logic                   w_sp_hit, w_sp_s, w_sp_zero, w_sp_inf;
    logic [EW-1:0]          w_sp_e;
    logic [MW-1:0]          w_sp_m;
    logic [EW:0]            w_d, w_dabs;
    logic                   w_swap;
    logic [MW-1:0]          w_y_pre, w_y_aligned;
    logic [MW:0]            w_sum, w_diff, w_diff_abs;
    logic                   w_nm_s, w_nm_zero, w_nm_ovf, w_nm_unf;
    logic [EW-1:0]          w_nm_e;
    logic [MW-1:0]          w_nm_m;

    always_comb begin
        w_a_inf  = (r_a_e == c_e_inf);
        w_a_zero = (r_a_e == c_e_zero);
        w_b_inf  = (r_b_e == c_e_inf);
        w_b_zero = (r_b_e == c_e_zero);

        // Special-operand result, in priority order (a inf wins, so inf-inf
        // simply returns a).
        w_sp_hit  = 1'b1;
        w_sp_s    = 1'b0;
        w_sp_e    = c_e_inf;
        w_sp_m    = c_m_one;
        w_sp_zero = 1'b0;
        w_sp_inf  = 1'b0;
        if (w_a_inf) begin
            w_sp_s   = r_a_s;
            w_sp_inf = 1'b1;
        end else if (w_b_inf) begin
            w_sp_s   = r_b_s;
            w_sp_inf = 1'b1;
        end else if (w_a_zero && w_b_zero) begin
            w_sp_e    = c_e_zero;
            w_sp_zero = 1'b1;
        end else if (w_a_zero) begin
            w_sp_s = r_b_s;
            w_sp_e = r_b_e;
            w_sp_m = r_b_m;
        end else if (w_b_zero) begin
            w_sp_s = r_a_s;
            w_sp_e = r_a_e;
            w_sp_m = r_a_m;
        end else begin
            w_sp_hit = 1'b0;
        end

        // Exponent difference one bit wider than EW so it cannot wrap.
        w_d         = {r_a_e[EW-1], r_a_e} - {r_b_e[EW-1], r_b_e};
        w_swap      = w_d[EW];
        w_dabs      = w_swap ? -w_d : w_d;
        w_y_pre     = w_swap ? r_a_m : r_b_m;
        w_y_aligned = (w_dabs >= c_shift_out) ? '0 : (w_y_pre >> w_dabs);

        w_sum      = {1'b0, r_x_m} + {1'b0, r_y_m};
        w_diff     = {1'b0, r_x_m} - {1'b0, r_y_m};
        w_diff_abs = w_diff[MW] ? -w_diff : w_diff;

        // Final result once the mantissa is normalised (or exactly zero).
        w_nm_s    = r_sign;
        w_nm_e    = r_e[EW-1:0];
        w_nm_m    = r_m;
        w_nm_zero = 1'b0;
        w_nm_ovf  = 1'b0;
        w_nm_unf  = 1'b0;
        if (r_m == '0) begin
            w_nm_s    = 1'b0;
            w_nm_e    = c_e_zero;
            w_nm_m    = c_m_one;
            w_nm_zero = 1'b1;
        end else if (r_e > c_e_hi) begin
            w_nm_e   = c_e_inf;
            w_nm_m   = c_m_one;
            w_nm_ovf = 1'b1;
        end else if (r_e < c_e_lo) begin
            w_nm_s    = 1'b0;
            w_nm_e    = c_e_zero;
            w_nm_m    = c_m_one;
            w_nm_unf  = 1'b1;
            w_nm_zero = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res_s  <= 1'b0;
            r_res_e  <= '0;
            r_res_m  <= '0;
            r_zero_f <= 1'b0;
            r_ovf_f  <= 1'b0;
            r_unf_f  <= 1'b0;
            r_inf_f  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a_s   <= bus.a_s;
                        r_a_e   <= bus.a_e;
                        r_a_m   <= bus.a_m;
                        r_b_s   <= bus.b_s ^ bus.op;
                        r_b_e   <= bus.b_e;
                        r_b_m   <= bus.b_m;
                        r_busy  <= 1'b1;
                        r_state <= S_SPECIAL;
                    end
                end
                S_SPECIAL: begin
                    if (w_sp_hit) begin
                        r_res_s  <= w_sp_s;
                        r_res_e  <= w_sp_e;
                        r_res_m  <= w_sp_m;
                        r_zero_f <= w_sp_zero;
                        r_ovf_f  <= 1'b0;
                        r_unf_f  <= 1'b0;
                        r_inf_f  <= w_sp_inf;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_x_s   <= w_swap ? r_b_s : r_a_s;
                    r_y_s   <= w_swap ? r_a_s : r_b_s;
                    r_x_m   <= w_swap ? r_b_m : r_a_m;
                    r_y_m   <= w_y_aligned;
                    r_ex    <= w_swap ? {{2{r_b_e[EW-1]}}, r_b_e} : {{2{r_a_e[EW-1]}}, r_a_e};
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    if (r_x_s == r_y_s) begin
                        r_sign <= r_x_s;
                        if (w_sum[MW]) begin
                            r_m <= w_sum[MW:1];
                            r_e <= r_ex + c_e_one;
                        end else begin
                            r_m <= w_sum[MW-1:0];
                            r_e <= r_ex;
                        end
                    end else begin
                        // Negative difference only arises for equal exponents.
                        r_sign <= r_x_s ^ w_diff[MW];
                        r_m    <= w_diff_abs[MW-1:0];
                        r_e    <= r_ex;
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if ((r_m != '0) && !r_m[MW-1]) begin
                        r_m <= {r_m[MW-2:0], 1'b0};
                        r_e <= r_e - c_e_one;
                    end else begin
                        r_res_s  <= w_nm_s;
                        r_res_e  <= w_nm_e;
                        r_res_m  <= w_nm_m;
                        r_zero_f <= w_nm_zero;
                        r_ovf_f  <= w_nm_ovf;
                        r_unf_f  <= w_nm_unf;
                        r_inf_f  <= w_nm_ovf;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.res_s          = r_res_s;
    assign bus.res_e          = r_res_e;
    assign bus.res_m          = r_res_m;
    assign bus.zero_flag      = r_zero_f;
    assign bus.overflow_flag  = r_ovf_f;
    assign bus.underflow_flag = r_unf_f;
    assign bus.inf_flag       = r_inf_f;

endmodule
`default_nettype wire

// File: doc/zuse_fpu_addsub.md
# zuse_fpu_addsub

Parametrised, handshaked floating-point add/subtract unit for the tinyZuse datapath. It supports configurable exponent and mantissa widths and latches its operands at start, so callers need not hold the register file stable. Special operands (zero and infinity) are detected explicitly, and normalization is iterative, one bit per cycle. It sits between the register file and the result register and replaces the fixed 7/15-bit adder.

## Interface
- EW, 7: exponent width; two's complement signed.
- MW, 15: mantissa width; explicit leading one at bit MW-1.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- op  in  1  0 = add, 1 = subtract (a - b).
- a_s, b_s  in  1  operand signs.
- a_e, b_e  in  EW  operand exponents.
- a_m, b_m  in  MW  operand mantissas.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- res_s / res_e / res_m  out  1 / EW / MW  result; held until the next done.
- zero_flag, overflow_flag, underflow_flag, inf_flag  out  1 each  status of the last result; held until the next done.

## Operation
- Value encoding: (-1)^s · m/2^(MW-1) · 2^e.
- Normal operands: m[MW-1]=1, with e in EMIN+1..EMAX-1, where EMIN = -2^(EW-1) and EMAX = 2^(EW-1)-1.
- Zero is encoded as e=EMIN, m=100..0.
- Infinity is encoded as e=EMAX, m=100..0.
- Any operand with e=EMIN is treated as zero, and any with e=EMAX as infinity, regardless of m.
- **IDLE:** on start, latch the operands. Effective b sign is bs = b_s ^ op. Set busy=1. Go to SPECIAL.
- **SPECIAL:** resolve special operands in this priority order.
  - a inf: result inf with sign a_s, inf_flag=1. This also covers inf-inf; no invalid flag.
  - else b inf: result inf with sign bs, inf_flag=1.
  - else both zero: result zero with sign 0, zero_flag=1.
  - else a zero: result is b with sign bs.
  - else b zero: result is a.
  - Any of the cases above writes the result and goes to IDLE with done.
  - Otherwise go to ALIGN.
- **ALIGN:** compute d = a_e - b_e at EW+1 bits.
  - d>=0: X=a (exponent ex = a_e), Y=b.
  - d<0: swap the operands and use |d|.
  - Shift Y.m right by |d|, truncating. If |d| >= MW, Y.m = 0.
  - Result sign starts as X's sign.
- **ADD:** operate on an (MW+1)-bit datapath.
  - Same signs: S = X.m + Y.m. If S[MW]=1, m = S>>1 and e = ex+1; else m = S, e = ex.
  - Different signs: D = X.m - Y.m. If D is negative (possible only when d=0), negate it and invert the sign. Then m = D, e = ex.
  - If m = 0: result zero with sign 0, zero_flag=1.
  - Go to NORM.
- **NORM:** each cycle, if m[MW-1]=0, shift m left by 1 and decrement e. Once m[MW-1]=1, perform the range check, write the result, and pulse done.
  - e > EMAX-1: result inf with the current sign, overflow_flag=1, inf_flag=1.
  - e < EMIN+1: result zero with sign 0, underflow_flag=1, zero_flag=1.
  - Exponent arithmetic uses EW+2 bits internally, so it never wraps.
- **Flags:** all four flags are cleared and rewritten at every done. More than one may be set at once (overflow+inf, underflow+zero).
- **Rounding:** none; truncation only.

## Timing
- Reset: state IDLE. busy, done, res_s, res_e, res_m and all flags are 0.
- Reset mid-operation aborts the operation; no done is produced.
- Start is sampled at edge T.
  - busy=1 from T until the edge that sets done. busy=0 while done=1.
  - Special path: done is set at edge T+1.
  - Zero-difference path: done is set at edge T+4.
  - Normal path: done is set at edge T+4+k, where k is the number of normalization shifts (0..MW-1).
- done is high for exactly one cycle.
- start while busy=1 is ignored and does not queue.
- start in the same cycle done=1 is accepted.
- Operand inputs are don't-care after edge T.

## Test plan
All scenarios use EW=7, MW=15.
- **Add:** 1.0 + 1.0, i.e. (e=0, m=0x4000) + (e=0, m=0x4000) -> res_e=1, m=0x4000, s=0, flags 0, done at T+4.
- **Subtract with normalization and sign flip:**
  - 1.5 - 1.0, i.e. (0, 0x6000) - (0, 0x4000) -> e=-1 (0x7F), m=0x4000, s=0, done at T+5.
  - 1.0 - 1.5 -> same result with s=1.
- **Cancellation:** x - x with x = (5, 0x5555) -> e=0x40, m=0x4000, zero_flag=1, done at T+4.
- **Overflow and underflow:**
  - (62, 0x4000) + (62, 0x4000) -> e=0x3F, m=0x4000, overflow_flag=1, inf_flag=1.
  - (-63, 0x6000) - (-63, 0x4000) -> e=0x40, m=0x4000, s=0, underflow_flag=1, zero_flag=1.
- **Alignment shift-out:** (0, 0x4000) + (-20, 0x4000) -> (0, 0x4000).
- **Special operands:**
  - inf - inf -> e=0x3F, s=a_s, inf_flag=1, done at T+1.
  - 0 - (3, 0x4000) -> (3, 0x4000) with s=1.
- **Handshake and reset:**
  - start pulsed at T+2 while busy -> ignored; exactly one done.
  - reset at T+2 -> busy=0, no done, all outputs 0.
